redmule_row_sched: RTL and testbench
====================================

Name: redmule_row_sched

Overview:
Sequencing controller for one RedMulE row of Height chained computing elements. Per job it accepts N operand beats from the streamer, drives the row's in_valid/reg_enable/flush controls and tracks every beat through the row's fixed latency with a valid shift register. It presents each finished row output with a valid/ready handshake and stalls the whole row on output backpressure. It sits between the streamer/engine FSM and the row datapath.

Parameters:
Height, 4, number of CEs in the row.
NumPipeRegs, 2, pipeline registers per CE.
CntW, 16, width of job beat counters.
Latency (localparam), Height*(NumPipeRegs+1), enabled cycles from beat issue to row output.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  job descriptor valid
cfg_ready_o  out  1  scheduler idle, descriptor accepted on valid&ready
cfg_beats_i  in  CntW  beats N in job
beat_valid_i  in  1  streamer has x/w/bias beat
beat_ready_o  out  1  beat consumed this cycle
row_in_valid_o  out  1  to row in_valid_i; equals beat handshake
row_reg_enable_o  out  1  to row reg_enable_i; pipeline advance
row_flush_o  out  1  to row flush_i
z_valid_o  out  1  row z_output is a valid result
z_ready_i  in  1  consumer accepts result
abort_i  in  1  cancel current job
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle job-complete pulse
issued_o  out  CntW  beats issued in current job
produced_o  out  CntW  results delivered in current job

Behaviour:
- Reset: state IDLE, valid shift register vld[Latency-1:0]=0, counters 0, done_o=0, row_flush_o=0; hence cfg_ready_o=1, beat_ready_o=0, z_valid_o=0, row_reg_enable_o=1, busy_o=0. Reset mid-job discards everything; no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_ready_o=1. On cfg_valid_i: latch N, clear counters; N=0 -> DONE, else -> RUN.
- advance = !(vld[Latency-1] && !z_ready_i). row_reg_enable_o = advance in all states; bubbles still advance.
- beat_ready_o = (state==RUN) && advance && (issued<N). row_in_valid_o = beat_valid_i && beat_ready_o.
- When advance: vld shifts one toward Latency-1, vld[0] <= row_in_valid_o. When !advance: vld holds.
- z_valid_o = vld[Latency-1]. Delivery = z_valid_o && z_ready_i; increments produced.
- Each beat handshake increments issued. The increment that makes issued==N moves RUN -> DRAIN.
- DRAIN: no beat acceptance. The delivery that makes produced==N -> DONE.
- DONE: done_o=1 for exactly one cycle -> IDLE. busy_o=1 in DONE.
- abort_i in RUN/DRAIN/DONE: next cycle row_flush_o=1 for one cycle, vld cleared, counters cleared, state IDLE, no done pulse. abort_i in IDLE is ignored. Abort has priority over every same-cycle handshake and transition; a delivery in that cycle still counts externally, but its beat counts are discarded.
- Simultaneous issue and delivery in one cycle is legal; both counters update.
- Latency-exact: with no backpressure, a beat issued in cycle t yields z_valid_o in cycle t+Latency.
- Counters never wrap. cfg_beats_i up to 2^CntW-1 is supported.
- In RUN, z_valid_o may assert before all beats are issued.

Test Plan:
- Reset, then N=1, beat at cycle 0, z_ready_i=1 -> z_valid_o at cycle 12 (Height=4, NumPipeRegs=2), done_o at cycle 13, cfg_ready_o=1 at cycle 14.
- N=8 back-to-back beats, z_ready_i=1 -> beat_ready_o high 8 consecutive cycles, z_valid_o high cycles 12..19, produced_o=8, single done_o.
- N=4, z_ready_i=0 for 5 cycles once first result appears -> row_reg_enable_o=0 and beat_ready_o=0 during the stall, vld frozen, result held stable, no loss or duplication, all 4 delivered.
- N=4 with beat_valid_i gaps (beats at cycles 0,2,3,7) -> results at 12,14,15,19, bubbles advance.
- N=6, abort_i after 3 beats issued -> row_flush_o pulse next cycle, z_valid_o=0, issued_o=produced_o=0, no done_o; a fresh N=2 job then completes normally.
- N=0 descriptor -> done_o one cycle after acceptance, no beat_ready_o, no row_in_valid_o.

Source files
------------

// File: rtl/redmule_row_sched.sv
// Row sequencer for one RedMulE row: issues operand beats, tracks them through the
// fixed-latency CE chain and hands finished results out under valid/ready backpressure.
module redmule_row_sched #(
  parameter int unsigned Height      = 4,
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned CntW        = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [CntW-1:0] cfg_beats_i,
  input  logic            beat_valid_i,
  output logic            beat_ready_o,
  output logic            row_in_valid_o,
  output logic            row_reg_enable_o,
  output logic            row_flush_o,
  output logic            z_valid_o,
  input  logic            z_ready_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [CntW-1:0] issued_o,
  output logic [CntW-1:0] produced_o
);

  localparam int unsigned Latency = Height * (NumPipeRegs + 1);
  localparam logic [CntW-1:0] One = {{(CntW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state;
  logic [Latency-1:0] vld;
  logic [Latency-1:0] vld_nxt;
  logic [CntW-1:0]   beats;
  logic [CntW-1:0]   issued;
  logic [CntW-1:0]   produced;
  logic [CntW-1:0]   issued_inc;
  logic [CntW-1:0]   produced_inc;
  logic              done;
  logic              flush;
  logic              advance;
  logic              beat_ready;
  logic              beat_fire;
  logic              delivery;
  logic              aborting;

  // Handshake and pipeline-advance decode; the whole row freezes only while a result waits.
  always_comb begin
    advance      = !(vld[Latency-1] && !z_ready_i);
    beat_ready   = (state == RUN) && advance && (issued < beats);
    beat_fire    = beat_valid_i && beat_ready;
    delivery     = vld[Latency-1] && z_ready_i;
    aborting     = abort_i && (state != IDLE);
    issued_inc   = issued + One;
    produced_inc = produced + One;
  end

  // Next valid-shift contents when the row advances; bubbles shift in as zeros.
  always_comb begin
    vld_nxt    = vld;
    vld_nxt[0] = beat_fire;
    for (int i = 1; i < Latency; i++) begin
      vld_nxt[i] = vld[i-1];
    end
  end

  // Scheduler FSM, valid tracker and job counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      vld      <= '0;
      beats    <= '0;
      issued   <= '0;
      produced <= '0;
      done     <= 1'b0;
      flush    <= 1'b0;
    end else begin
      done  <= 1'b0;
      flush <= 1'b0;
      if (aborting) begin
        // Abort wins over every same-cycle handshake; in-flight beats are discarded.
        state    <= IDLE;
        vld      <= '0;
        issued   <= '0;
        produced <= '0;
        flush    <= 1'b1;
      end else begin
        if (advance) begin
          vld <= vld_nxt;
        end else begin
          vld <= vld;
        end
        case (state)
          IDLE: begin
            if (cfg_valid_i) begin
              beats    <= cfg_beats_i;
              issued   <= '0;
              produced <= '0;
              if (cfg_beats_i == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              state <= IDLE;
            end
          end
          RUN: begin
            if (beat_fire) begin
              issued <= issued_inc;
              if (issued_inc == beats) begin
                state <= DRAIN;
              end else begin
                state <= RUN;
              end
            end else begin
              state <= RUN;
            end
            if (delivery && (produced < beats)) begin
              produced <= produced_inc;
            end else begin
              produced <= produced;
            end
          end
          DRAIN: begin
            if (delivery && (produced < beats)) begin
              produced <= produced_inc;
              if (produced_inc == beats) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end else begin
              state <= DRAIN;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready_o      = (state == IDLE);
  assign busy_o           = (state != IDLE);
  assign beat_ready_o     = beat_ready;
  assign row_in_valid_o   = beat_fire;
  assign row_reg_enable_o = advance;
  assign row_flush_o      = flush;
  assign z_valid_o        = vld[Latency-1];
  assign done_o           = done;
  assign issued_o         = issued;
  assign produced_o       = produced;

endmodule

// File: tb/tb_redmule_row_sched.sv
// Directed bench for redmule_row_sched (Height=4, NumPipeRegs=2 -> latency 12).
module tb_redmule_row_sched;

  logic        clk_i;
  logic        rst_ni;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [15:0] cfg_beats_i;
  logic        beat_valid_i;
  logic        beat_ready_o;
  logic        row_in_valid_o;
  logic        row_reg_enable_o;
  logic        row_flush_o;
  logic        z_valid_o;
  logic        z_ready_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] issued_o;
  logic [15:0] produced_o;

  int n_checks = 0;
  int n_fail   = 0;

  redmule_row_sched #(.Height(4), .NumPipeRegs(2), .CntW(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_beats_i(cfg_beats_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .row_in_valid_o(row_in_valid_o), .row_reg_enable_o(row_reg_enable_o),
    .row_flush_o(row_flush_o), .z_valid_o(z_valid_o), .z_ready_i(z_ready_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .issued_o(issued_o), .produced_o(produced_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = 64'd0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a descriptor for one cycle; the window after it starts at job cycle 0.
  task automatic accept(input string name, input logic [15:0] n);
    cfg_valid_i  = 1'b1;
    cfg_beats_i  = n;
    beat_valid_i = 1'b0;
    z_ready_i    = 1'b1;
    @(negedge clk_i);
    check_val({name, ".cfg_ready"}, 32'(cfg_ready_o), 32'd1);
    check_val({name, ".beat_ready_idle"}, 32'(beat_ready_o), 32'd0);
    tick();
    cfg_valid_i = 1'b0;
    cfg_beats_i = 16'd0;
  endtask

  // Drive per-cycle beat_valid/z_ready masks and check every output against expected masks.
  task automatic run_window(input string name, input int ncyc,
                            input logic [63:0] bv, input logic [63:0] zr,
                            input logic [63:0] br, input logic [63:0] zv,
                            input logic [63:0] dn, input logic [63:0] idle,
                            input int iss0, input int prod0);
    int iss;
    int prod;
    iss  = iss0;
    prod = prod0;
    for (int c = 0; c < ncyc; c++) begin
      beat_valid_i = bv[c];
      z_ready_i    = zr[c];
      @(negedge clk_i);
      check_val($sformatf("%s.beat_ready@%0d", name, c), 32'(beat_ready_o), 32'(br[c]));
      check_val($sformatf("%s.in_valid@%0d", name, c), 32'(row_in_valid_o), 32'(bv[c] & br[c]));
      check_val($sformatf("%s.z_valid@%0d", name, c), 32'(z_valid_o), 32'(zv[c]));
      check_val($sformatf("%s.reg_en@%0d", name, c), 32'(row_reg_enable_o), 32'(!(zv[c] && !zr[c])));
      check_val($sformatf("%s.done@%0d", name, c), 32'(done_o), 32'(dn[c]));
      check_val($sformatf("%s.cfg_ready@%0d", name, c), 32'(cfg_ready_o), 32'(idle[c]));
      check_val($sformatf("%s.busy@%0d", name, c), 32'(busy_o), 32'(!idle[c]));
      check_val($sformatf("%s.flush@%0d", name, c), 32'(row_flush_o), 32'd0);
      check_val($sformatf("%s.issued@%0d", name, c), 32'(issued_o), 32'(iss));
      check_val($sformatf("%s.produced@%0d", name, c), 32'(produced_o), 32'(prod));
      if (bv[c] && br[c]) iss++;
      if (zv[c] && zr[c]) prod++;
      tick();
    end
    beat_valid_i = 1'b0;
    z_ready_i    = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    cfg_valid_i  = 1'b0;
    cfg_beats_i  = 16'd0;
    beat_valid_i = 1'b0;
    z_ready_i    = 1'b1;
    abort_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst.cfg_ready", 32'(cfg_ready_o), 32'd1);
    check_val("rst.beat_ready", 32'(beat_ready_o), 32'd0);
    check_val("rst.z_valid", 32'(z_valid_o), 32'd0);
    check_val("rst.reg_en", 32'(row_reg_enable_o), 32'd1);
    check_val("rst.busy", 32'(busy_o), 32'd0);
    check_val("rst.done", 32'(done_o), 32'd0);
    check_val("rst.flush", 32'(row_flush_o), 32'd0);
    check_val("rst.issued", 32'(issued_o), 32'd0);
    check_val("rst.produced", 32'(produced_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // N=1: result at 12, done at 13, idle at 14
    accept("n1", 16'd1);
    run_window("n1", 15, rng(0, 0), ~64'd0, rng(0, 0), rng(12, 12), rng(13, 13), rng(14, 14), 0, 0);
    check_val("n1.final_produced", 32'(produced_o), 32'd1);

    // N=8 back-to-back
    accept("n8", 16'd8);
    run_window("n8", 22, rng(0, 7), ~64'd0, rng(0, 7), rng(12, 19), rng(20, 20), rng(21, 21), 0, 0);
    check_val("n8.final_produced", 32'(produced_o), 32'd8);
    check_val("n8.final_issued", 32'(issued_o), 32'd8);

    // N=4 with 5-cycle backpressure starting at the first result
    accept("stall", 16'd4);
    run_window("stall", 23, rng(0, 3), ~rng(12, 16), rng(0, 3), rng(12, 20), rng(21, 21), rng(22, 22), 0, 0);
    check_val("stall.final_produced", 32'(produced_o), 32'd4);

    // N=4 with beat gaps: beats at 0,2,3,7 -> results at 12,14,15,19
    accept("gaps", 16'd4);
    run_window("gaps", 22, rng(0, 0) | rng(2, 3) | rng(7, 7), ~64'd0, rng(0, 7),
               rng(12, 12) | rng(14, 15) | rng(19, 19), rng(20, 20), rng(21, 21), 0, 0);

    // N=6, abort after three beats
    accept("abort", 16'd6);
    run_window("abort", 3, rng(0, 2), ~64'd0, rng(0, 2), 64'd0, 64'd0, 64'd0, 0, 0);
    abort_i = 1'b1;
    @(negedge clk_i);
    check_val("abort.busy_at_req", 32'(busy_o), 32'd1);
    check_val("abort.issued_at_req", 32'(issued_o), 32'd3);
    tick();
    abort_i = 1'b0;
    @(negedge clk_i);
    check_val("abort.flush", 32'(row_flush_o), 32'd1);
    check_val("abort.z_valid", 32'(z_valid_o), 32'd0);
    check_val("abort.issued", 32'(issued_o), 32'd0);
    check_val("abort.produced", 32'(produced_o), 32'd0);
    check_val("abort.cfg_ready", 32'(cfg_ready_o), 32'd1);
    check_val("abort.busy", 32'(busy_o), 32'd0);
    check_val("abort.done", 32'(done_o), 32'd0);
    tick();
    // in-flight beats must never emerge and no done may follow
    run_window("post_abort", 15, 64'd0, ~64'd0, 64'd0, 64'd0, 64'd0, ~64'd0, 0, 0);

    // fresh N=2 job after abort
    accept("n2", 16'd2);
    run_window("n2", 16, rng(0, 1), ~64'd0, rng(0, 1), rng(12, 13), rng(14, 14), rng(15, 15), 0, 0);

    // N=0: done one cycle after acceptance, beats offered but never taken
    accept("n0", 16'd0);
    run_window("n0", 3, ~64'd0, ~64'd0, 64'd0, 64'd0, rng(0, 0), rng(1, 2), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
